add_sub_multicycle: RTL

Parametrised two's-complement adder/subtractor with the same A/B/M/C/S/V contract as the team's 4-bit ripple add/sub. It processes a WIDTH-bit operation as WIDTH/CHUNK sequential CHUNK-bit ripple slices, one slice per clock, which trades latency for area. It adds a start/ready/done handshake and an accumulate mode that reuses the previous result as operand A. It serves as the arithmetic unit for datapaths wider than the combinational 4-bit block supports.

---
 rtl/add_sub_multicycle.sv | 139 +++++++++++++
 1 files changed

// File: rtl/add_sub_multicycle.sv
`default_nettype none
// ============================================================================
//  Module   : add_sub_multicycle
//  Purpose  : Two's-complement add/subtract of WIDTH bits, one CHUNK-bit
//             ripple slice per clock, with start/ready/done and accumulate.
//  Revision : 1.0  initial release
// ============================================================================
module add_sub_multicycle #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             M,
    input  logic             ACC,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             V
);

    localparam int c_nchunk = WIDTH / CHUNK;
    localparam int c_cnt_w  = (c_nchunk > 1) ? $clog2(c_nchunk) : 1;

    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_run  = 1'b1;

    generate
        if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
            $error("add_sub_multicycle: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_s;
    logic               r_carry;
    logic               r_c;
    logic               r_v;
    logic               r_done;
    logic [CHUNK-1:0]   w_sum;
    logic               w_cin_top;
    logic               w_cout;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_last;
    logic               w_accept;
    logic               w_run;

    // Operands shift down one slice per cycle, so the active slice is always
    // the low CHUNK bits; result slices enter from the top.
    always_comb begin : p_ripple
        logic [CHUNK:0] w_chain;
        w_chain    = '0;
        w_sum      = '0;
        w_chain[0] = r_carry;
        for (int i = 0; i < CHUNK; i++) begin
            w_sum[i]       = r_opa[i] ^ r_opb[i] ^ w_chain[i];
            w_chain[i + 1] = (r_opa[i] & r_opb[i]) | (w_chain[i] & (r_opa[i] ^ r_opb[i]));
        end
        w_cin_top = w_chain[CHUNK-1];
        w_cout    = w_chain[CHUNK];
    end

    assign w_res_next = WIDTH'({w_sum, r_res} >> CHUNK);
    assign w_last     = (r_cnt == c_cnt_w'(c_nchunk - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle:  if (start)  w_state_next = c_run;
            c_run:   if (w_last) w_state_next = c_idle;
            default: w_state_next = c_idle;
        endcase
    end

    always_comb begin
        ready    = (r_state == c_idle);
        w_accept = start && (r_state == c_idle);
        w_run    = (r_state == c_run);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_s     <= '0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_run && w_last;
            if (w_accept) begin
                r_opa   <= ACC ? r_s : A;
                r_opb   <= B ^ {WIDTH{M}};
                r_carry <= M;
                r_cnt   <= '0;
            end else if (w_run) begin
                r_opa   <= r_opa >> CHUNK;
                r_opb   <= r_opb >> CHUNK;
                r_res   <= w_res_next;
                r_carry <= w_cout;
                if (w_last) begin
                    r_cnt <= '0;
                    r_s   <= w_res_next;
                    r_c   <= w_cout;
                    r_v   <= w_cin_top ^ w_cout;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign done = r_done;
    assign S    = r_s;
    assign C    = r_c;
    assign V    = r_v;

endmodule
`default_nettype wire
